// File: rtl/light_sequencer_if.sv
// rtl/light_sequencer_if.sv - control and status bundle between a host and the light sequencer
interface light_sequencer_if #(
  parameter int TW = 8
);
  logic          start;
  logic          stop;
  logic [1:0]    mode;
  logic [TW-1:0] period;
  logic [7:0]    nsteps;
  logic          button;
  logic          sel;
  logic          busy;
  logic          done;
  logic [7:0]    step_cnt;

  modport master (
    output start, stop, mode, period, nsteps,
    input  button, sel, busy, done, step_cnt
  );

  modport slave (
    input  start, stop, mode, period, nsteps,
    output button, sel, busy, done, step_cnt
  );
endinterface

// File: rtl/light_sequencer.sv
// rtl/light_sequencer.sv - timed step generator driving a lights selector (button advance, white select)
module light_sequencer #(
  parameter int TW = 8
) (
  input  logic             clk,
  input  logic             rst,
  light_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [TW-1:0] period_q, period_d;
  logic [7:0]    nsteps_q, nsteps_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    step_cnt_q, step_cnt_d;
  logic          button_q, button_d;
  logic          sel_q, sel_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  localparam logic [TW-1:0] ONE = {{(TW-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      mode_q     <= 2'b00;
      period_q   <= '0;
      nsteps_q   <= 8'd0;
      timer_q    <= '0;
      step_cnt_q <= 8'd0;
      button_q   <= 1'b0;
      sel_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      period_q   <= period_d;
      nsteps_q   <= nsteps_d;
      timer_q    <= timer_d;
      step_cnt_q <= step_cnt_d;
      button_q   <= button_d;
      sel_q      <= sel_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    period_d   = period_q;
    nsteps_d   = nsteps_q;
    timer_d    = timer_q;
    step_cnt_d = step_cnt_q;
    button_d   = 1'b0;
    sel_d      = sel_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        sel_d  = 1'b0;
        busy_d = 1'b0;
        if (bus.start && !bus.stop && (bus.period != '0)) begin
          mode_d     = (bus.mode == 2'b11) ? 2'b00 : bus.mode;
          period_d   = bus.period;
          nsteps_d   = bus.nsteps;
          timer_d    = bus.period - ONE;
          step_cnt_d = 8'd0;
          busy_d     = 1'b1;
          state_d    = RUN;
        end
      end

      RUN: begin
        // stop takes priority over a step landing on the same edge
        if (bus.stop) begin
          state_d = IDLE;
          sel_d   = 1'b0;
          busy_d  = 1'b0;
        end else if (timer_q == '0) begin
          timer_d    = period_q - ONE;
          step_cnt_d = step_cnt_q + 8'd1;
          case (mode_q)
            2'b01: sel_d = ~sel_q;
            2'b10: begin
              sel_d    = ~sel_q;
              button_d = sel_q;
            end
            default: button_d = 1'b1;
          endcase
          if ((nsteps_q != 8'd0) && (step_cnt_d == nsteps_q)) begin
            state_d = DONE;
          end
        end else begin
          timer_d = timer_q - ONE;
        end
      end

      DONE: begin
        // final step's outputs are visible this cycle; done follows on the next
        state_d = IDLE;
        sel_d   = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end

      default: begin
        state_d = IDLE;
        sel_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.button   = button_q;
  assign bus.sel      = sel_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.step_cnt = step_cnt_q;

endmodule

// File: tb/tb_light_sequencer.sv
// tb/tb_light_sequencer.sv - directed vector table plus hand sequences for light_sequencer
module tb_light_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  light_sequencer_if #(.TW(8)) bus ();

  light_sequencer #(.TW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       start;
    logic       stop;
    logic [1:0] mode;
    logic [7:0] period;
    logic [7:0] nsteps;
    logic       e_button;
    logic       e_sel;
    logic       e_busy;
    logic       e_done;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic st, input logic sp, input logic [1:0] m,
                              input logic [7:0] p, input logic [7:0] n,
                              input logic b, input logic s, input logic bz,
                              input logic d, input logic [7:0] c);
    vec_t v;
    v = '{st, sp, m, p, n, b, s, bz, d, c};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic b, input logic s, input logic bz,
                            input logic d, input logic [7:0] c);
    check({tag, ".button"}, {31'd0, bus.button}, {31'd0, b});
    check({tag, ".sel"}, {31'd0, bus.sel}, {31'd0, s});
    check({tag, ".busy"}, {31'd0, bus.busy}, {31'd0, bz});
    check({tag, ".done"}, {31'd0, bus.done}, {31'd0, d});
    check({tag, ".step_cnt"}, {24'd0, bus.step_cnt}, {24'd0, c});
  endtask

  task automatic drive(input logic st, input logic sp, input logic [1:0] m,
                       input logic [7:0] p, input logic [7:0] n);
    bus.start  = st;
    bus.stop   = sp;
    bus.mode   = m;
    bus.period = p;
    bus.nsteps = n;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 1'b0, 2'b00, 8'd0, 8'd0);
    #2 rst = 1'b0;
    #2 check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    rst = 1'b1;

    // mode 00 period 4 nsteps 3, with start and setting changes mid-run, then idle-side corners
    tbl.push_back(mk(1, 0, 2'd0, 8'd4, 8'd3, 0, 0, 1, 0, 8'd0));
    tbl.push_back(mk(0, 0, 2'd0, 8'd4, 8'd3, 0, 0, 1, 0, 8'd0));
    tbl.push_back(mk(1, 0, 2'd1, 8'd2, 8'd1, 0, 0, 1, 0, 8'd0));
    tbl.push_back(mk(0, 0, 2'd2, 8'd7, 8'd9, 0, 0, 1, 0, 8'd0));
    tbl.push_back(mk(0, 0, 2'd0, 8'd4, 8'd3, 1, 0, 1, 0, 8'd1));
    tbl.push_back(mk(0, 0, 2'd0, 8'd4, 8'd3, 0, 0, 1, 0, 8'd1));
    tbl.push_back(mk(0, 0, 2'd0, 8'd4, 8'd3, 0, 0, 1, 0, 8'd1));
    tbl.push_back(mk(0, 0, 2'd0, 8'd4, 8'd3, 0, 0, 1, 0, 8'd1));
    tbl.push_back(mk(0, 0, 2'd0, 8'd4, 8'd3, 1, 0, 1, 0, 8'd2));
    tbl.push_back(mk(0, 0, 2'd0, 8'd4, 8'd3, 0, 0, 1, 0, 8'd2));
    tbl.push_back(mk(0, 0, 2'd0, 8'd4, 8'd3, 0, 0, 1, 0, 8'd2));
    tbl.push_back(mk(0, 0, 2'd0, 8'd4, 8'd3, 0, 0, 1, 0, 8'd2));
    tbl.push_back(mk(0, 0, 2'd0, 8'd4, 8'd3, 1, 0, 1, 0, 8'd3));
    tbl.push_back(mk(0, 0, 2'd0, 8'd4, 8'd3, 0, 0, 0, 1, 8'd3));
    tbl.push_back(mk(0, 0, 2'd0, 8'd4, 8'd3, 0, 0, 0, 0, 8'd3));
    tbl.push_back(mk(1, 0, 2'd0, 8'd0, 8'd3, 0, 0, 0, 0, 8'd3));
    tbl.push_back(mk(0, 0, 2'd0, 8'd0, 8'd3, 0, 0, 0, 0, 8'd3));
    tbl.push_back(mk(1, 1, 2'd0, 8'd4, 8'd3, 0, 0, 0, 0, 8'd3));
    tbl.push_back(mk(0, 0, 2'd0, 8'd4, 8'd3, 0, 0, 0, 0, 8'd3));
    // mode 11 behaves as 00; period 1 holds button high
    tbl.push_back(mk(1, 0, 2'd3, 8'd1, 8'd2, 0, 0, 1, 0, 8'd0));
    tbl.push_back(mk(0, 0, 2'd3, 8'd1, 8'd2, 1, 0, 1, 0, 8'd1));
    tbl.push_back(mk(0, 0, 2'd3, 8'd1, 8'd2, 1, 0, 1, 0, 8'd2));
    tbl.push_back(mk(0, 0, 2'd3, 8'd1, 8'd2, 0, 0, 0, 1, 8'd2));
    tbl.push_back(mk(0, 0, 2'd3, 8'd1, 8'd2, 0, 0, 0, 0, 8'd2));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].start, tbl[i].stop, tbl[i].mode, tbl[i].period, tbl[i].nsteps);
      tick();
      check_outs($sformatf("vec%0d", i), tbl[i].e_button, tbl[i].e_sel,
                 tbl[i].e_busy, tbl[i].e_done, tbl[i].e_cnt);
    end

    // mode 01 period 5 nsteps 4: sel 1,0,1,0 every 5 cycles, done at cycle 21
    drive(1, 0, 2'd1, 8'd5, 8'd4);
    tick();
    check_outs("blink.c0", 0, 0, 1, 0, 8'd0);
    drive(0, 0, 2'd1, 8'd5, 8'd4);
    for (int c = 1; c <= 22; c++) begin
      tick();
      check_outs($sformatf("blink.c%0d", c), 1'b0,
                 ((c >= 5 && c < 10) || (c >= 15 && c < 20)),
                 (c <= 20), (c == 21), (c <= 20) ? 8'(c / 5) : 8'd4);
    end

    // mode 10 period 2 free-running, then stop
    drive(1, 0, 2'd2, 8'd2, 8'd0);
    tick();
    check_outs("pair.c0", 0, 0, 1, 0, 8'd0);
    drive(0, 0, 2'd2, 8'd2, 8'd0);
    for (int c = 1; c <= 20; c++) begin
      tick();
      check_outs($sformatf("pair.c%0d", c), (c % 4 == 0), ((c / 2) % 2 == 1),
                 1'b1, 1'b0, 8'(c / 2));
    end
    drive(0, 1, 2'd2, 8'd2, 8'd0);
    tick();
    check_outs("pair.stop", 0, 0, 0, 0, 8'd10);
    drive(0, 0, 2'd2, 8'd2, 8'd0);
    tick();
    check_outs("pair.after", 0, 0, 0, 0, 8'd10);

    // stop on the step edge, mode 00
    drive(1, 0, 2'd0, 8'd3, 8'd0);
    tick();
    drive(0, 0, 2'd0, 8'd3, 8'd0);
    tick();
    tick();
    check_outs("stopstep0.c2", 0, 0, 1, 0, 8'd0);
    drive(0, 1, 2'd0, 8'd3, 8'd0);
    tick();
    check_outs("stopstep0.c3", 0, 0, 0, 0, 8'd0);

    // stop on the step edge where mode 10 would drop sel and pulse button
    drive(1, 0, 2'd2, 8'd2, 8'd0);
    tick();
    drive(0, 0, 2'd2, 8'd2, 8'd0);
    tick();
    tick();
    check_outs("stopstep2.c2", 0, 1, 1, 0, 8'd1);
    tick();
    drive(0, 1, 2'd2, 8'd2, 8'd0);
    tick();
    check_outs("stopstep2.c4", 0, 0, 0, 0, 8'd1);
    drive(0, 0, 2'd0, 8'd2, 8'd0);

    // step counter wraps 255 -> 0
    drive(1, 0, 2'd0, 8'd1, 8'd0);
    tick();
    drive(0, 0, 2'd0, 8'd1, 8'd0);
    for (int c = 1; c <= 257; c++) begin
      tick();
      if (c >= 254) begin
        check_outs($sformatf("wrap.c%0d", c), 1'b1, 1'b0, 1'b1, 1'b0, 8'(c));
      end
    end
    drive(0, 1, 2'd0, 8'd1, 8'd0);
    tick();
    check_outs("wrap.stop", 0, 0, 0, 0, 8'd1);

    // asynchronous reset during mode 10 with sel high
    drive(1, 0, 2'd2, 8'd2, 8'd0);
    tick();
    drive(0, 0, 2'd2, 8'd2, 8'd0);
    tick();
    tick();
    check_outs("rstrun.pre", 0, 1, 1, 0, 8'd1);
    #2 rst = 1'b0;
    #1 check_outs("rstrun.async", 0, 0, 0, 0, 8'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      check_outs($sformatf("rstrun.idle%0d", c), 0, 0, 0, 0, 8'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/light_sequencer.md
LIGHT_SEQUENCER -- requirements
Module: light_sequencer

Interface
REQ-001 The block SHALL have parameter TW, default 8, setting the width of the step-period timer and the period input.
REQ-002 The block SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: start a sequence; sampled only in IDLE.
REQ-005 The block SHALL have port stop, input, 1 bit: abort the running sequence.
REQ-006 The block SHALL have port mode, input, 2 bits: 00 = colour step, 01 = white blink, 10 = step+blink, 11 = treated as 00.
REQ-007 The block SHALL have port period, input, TW bits: clock cycles per step; 0 = invalid.
REQ-008 The block SHALL have port nsteps, input, 8 bits: number of steps to run; 0 = run until stop.
REQ-009 The block SHALL have port button, output, 1 bit: advance request to the lights selector, one-cycle pulse per advance.
REQ-010 The block SHALL have port sel, output, 1 bit: white-select to the lights selector (1 = white).
REQ-011 The block SHALL have port busy, output, 1 bit: high while a sequence is running.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse on normal completion.
REQ-013 The block SHALL have port step_cnt, output, 8 bits: steps completed in the current sequence.

Function
REQ-014 The block SHALL implement FSM states IDLE, RUN and DONE; all outputs SHALL be registered.
REQ-015 In IDLE, if start=1 and period!=0, the block SHALL latch mode, period and nsteps, load timer=period-1, clear step_cnt, and enter RUN; busy SHALL be 1 from the next cycle.
REQ-016 In IDLE, start with period=0 SHALL be ignored, and the block SHALL remain in IDLE.
REQ-017 In RUN, start SHALL be ignored, and changes to mode, period or nsteps SHALL have no effect until the next start.
REQ-018 In RUN, the timer SHALL decrement each cycle; at timer=0 a step occurs, the timer reloads period-1, and step_cnt increments, wrapping 255->0.
REQ-019 A step in mode 00 SHALL assert button for exactly one cycle, with sel held at 0.
REQ-020 A step in mode 01 SHALL toggle sel, with button held at 0.
REQ-021 A step in mode 10 SHALL toggle sel; when sel goes 1->0, button SHALL pulse in that same cycle (colour advances once per white/colour pair).
REQ-022 When nsteps!=0 and the step that makes step_cnt equal nsteps occurs, the block SHALL enter DONE after that step's outputs.
REQ-023 DONE SHALL last one cycle with done=1, sel=0, button=0 and busy=0, then return to IDLE.
REQ-024 When stop=1 in RUN, the block SHALL go to IDLE on the next edge with button=0, sel=0, busy=0 and no done pulse; step_cnt SHALL hold its value.
REQ-025 When stop and a step occur in the same cycle, stop SHALL win: no button pulse and no sel toggle.
REQ-026 When stop and start are asserted together in IDLE, the block SHALL stay in IDLE.
REQ-027 Period=1 SHALL give a step every cycle; in mode 00 this SHALL hold button high continuously.
REQ-028 Button pulses SHALL never exceed one per step.
REQ-029 There SHALL be no combinational path from inputs to outputs.

Reset
REQ-030 On rst=0, the block SHALL asynchronously enter IDLE with button=0, sel=0, busy=0, done=0, step_cnt=0 and timer=0.
REQ-031 The reset SHALL take effect mid-sequence without completing the current step.
REQ-032 After rst returns to 1, the block SHALL require a new start before running.

Verification
REQ-033 The bench SHALL cover: rst=0 during RUN (mode 10, sel=1) -> all outputs 0 immediately, without waiting for a clk edge; no activity until the next start.
REQ-034 The bench SHALL cover: mode 00, period=4, nsteps=3 -> button pulses at cycles 4, 8 and 12 after start; done=1 at cycle 13; step_cnt=3; busy=0 afterwards.
REQ-035 The bench SHALL cover: mode 01, period=5, nsteps=4 -> sel toggles 1,0,1,0 every 5 cycles; button stays 0 throughout; done after the 4th toggle.
REQ-036 The bench SHALL cover: mode 10, period=2, nsteps=0 for 20 cycles, then stop -> sel toggles every 2 cycles; button pulses only on sel 1->0 (every 4 cycles); after stop, IDLE with no done pulse.
REQ-037 The bench SHALL cover: start with period=0 -> busy stays 0; start pulse during RUN -> timing unchanged.
REQ-038 The bench SHALL cover: stop asserted in the same cycle as timer=0 -> no button pulse and sel=0 on the next cycle.
